// File: rtl/riscv_pkg.sv
// Shared defaults and helpers for the RISC-V front end.
package riscv_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam int unsigned PC_STEP             = DEFAULT_INSTR_WIDTH / 8;
  // Bubble encoding (addi x0,x0,0) used when IF/ID is flushed.
  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FILL,
    RSP_DROP
  } rspAction_e;

  // Bits needed to hold the values 0..maxVal inclusive.
  function automatic int unsigned countWidth(input int unsigned maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and IF/ID handshake bundle.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [ADDR_WIDTH-1:0]  imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   if_valid;
  logic                   if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0]  if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue: slots are allocated with their PC at issue and
// filled in order as responses return; the head is presented once filled.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              allocValid,
  input  logic [ADDR_WIDTH-1:0]             allocPc,
  input  logic                              fillValid,
  input  logic [INSTR_WIDTH-1:0]            fillData,
  input  logic                              popValid,
  output logic                              headValid,
  output logic [ADDR_WIDTH-1:0]             headPc,
  output logic [INSTR_WIDTH-1:0]            headInstr,
  output logic [countWidth(DEPTH)-1:0]      occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = countWidth(DEPTH);

  logic [ADDR_WIDTH-1:0]  pcMem   [DEPTH];
  logic [INSTR_WIDTH-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]       filled;
  logic [PTR_W-1:0]       headPtr;
  logic [PTR_W-1:0]       tailPtr;
  logic [PTR_W-1:0]       fillPtr;
  logic [OCC_W-1:0]       occCnt;

  always_ff @(posedge clk) begin
    if (allocValid) pcMem[tailPtr]   <= allocPc;
    if (fillValid)  dataMem[fillPtr] <= fillData;
  end

  // fillPtr trails tailPtr and marks the oldest allocated-but-unfilled slot.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      fillPtr <= '0;
      occCnt  <= '0;
      filled  <= '0;
    end else begin
      if (allocValid) begin
        filled[tailPtr] <= 1'b0;
        tailPtr         <= tailPtr + PTR_W'(1);
      end
      if (fillValid) begin
        filled[fillPtr] <= 1'b1;
        fillPtr         <= fillPtr + PTR_W'(1);
      end
      if (popValid) headPtr <= headPtr + PTR_W'(1);
      occCnt <= occCnt + OCC_W'(allocValid) - OCC_W'(popValid);
    end
  end

  always_comb begin
    headValid = (occCnt != '0) && filled[headPtr];
    headPc    = pcMem[headPtr];
    headInstr = dataMem[headPtr];
    occupancy = occCnt;
  end

  occupancyBound: assert property (@(posedge clk) disable iff (rst)
    occCnt <= OCC_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues in-order memory requests,
// and discards responses that belong to requests made before a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH     = DEFAULT_INSTR_WIDTH,
  parameter int unsigned           FQ_DEPTH        = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2 * FQ_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master          bus
);

  localparam int unsigned           CNT_W   = countWidth(MAX_OUTSTANDING);
  localparam int unsigned           OCC_W   = countWidth(FQ_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(INSTR_WIDTH / 8);
  localparam logic [CNT_W-1:0]      MAX_OUT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [OCC_W-1:0]      DEPTH   = OCC_W'(FQ_DEPTH);

  logic [ADDR_WIDTH-1:0]  fetchPc;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       dropCnt;
  logic [OCC_W-1:0]       occupancy;
  logic                   reqValid;
  logic                   reqFire;
  logic                   rspFire;
  logic                   pop;
  logic                   headValid;
  logic [ADDR_WIDTH-1:0]  headPc;
  logic [INSTR_WIDTH-1:0] headInstr;
  rspAction_e             rspAction;

  always_comb begin
    reqValid  = !rst && !redirect_valid && (occupancy < DEPTH) && (outstanding < MAX_OUT);
    reqFire   = reqValid && bus.imem_req_ready;
    rspFire   = bus.imem_rsp_valid;
    rspAction = RSP_NONE;
    if (rspFire) rspAction = (redirect_valid || dropCnt != '0) ? RSP_DROP : RSP_FILL;
    pop       = headValid && !rst && bus.if_ready && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else if (redirect_valid) begin
      // A response landing in the redirect cycle is dropped on the spot,
      // so only the remaining in-flight requests are left to discard.
      fetchPc     <= redirect_pc;
      outstanding <= outstanding - CNT_W'(rspFire);
      dropCnt     <= outstanding - CNT_W'(rspFire);
    end else begin
      if (reqFire) fetchPc <= fetchPc + STEP;
      outstanding <= outstanding + CNT_W'(reqFire) - CNT_W'(rspFire);
      if (rspAction == RSP_DROP) dropCnt <= dropCnt - CNT_W'(1);
    end
  end

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .DEPTH      (FQ_DEPTH)
  ) queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .allocValid(reqFire),
    .allocPc   (fetchPc),
    .fillValid (rspAction == RSP_FILL),
    .fillData  (bus.imem_rsp_data),
    .popValid  (pop),
    .headValid (headValid),
    .headPc    (headPc),
    .headInstr (headInstr),
    .occupancy (occupancy)
  );

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc;
  assign bus.if_valid       = headValid && !rst;
  assign bus.if_instr       = headInstr;
  assign bus.if_pc          = headPc;

  noOrphanResponse: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model of the fetch rules,
// directed scenarios pinned by literal values, then randomized traffic.
module tb_fetch_unit;

  localparam int unsigned FQ   = 4;
  localparam int unsigned MAXO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirValid;
  logic [31:0] redirPc;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();
  fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus2 ();

  fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .FQ_DEPTH(FQ), .MAX_OUTSTANDING(MAXO),
               .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirValid), .redirect_pc(redirPc), .bus(bus));

  fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .FQ_DEPTH(FQ), .MAX_OUTSTANDING(MAXO),
               .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // reference model state (values after the most recent clock edge)
  logic [31:0] mPc;
  logic [31:0] qPc[$];
  logic [31:0] qData[$];
  bit          qFilled[$];
  int          mOut, mDrop;
  bit          started = 0;
  int          memDue[$];
  logic [31:0] memAddr[$];
  int          cycleNo = 0;

  // stimulus knobs
  bit          kRst, kRedir, kIfReady, kReqReady, kMemStop, kJitter;
  logic [31:0] kRedirPc;
  int          kLat;

  // logs since the last reset
  logic [31:0] issueLog[$], delivLog[$], dut2Log[$];
  int          discards, relCycle, firstDelivRel;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    bit rspV, expReqV, expIfV, reqFire, pop;
    logic [31:0] a;
    int idx;
    @(negedge clk);
    rst                  = kRst;
    redirValid           = kRedir;
    redirPc              = kRedirPc;
    bus.if_ready         = kIfReady;
    bus.imem_req_ready   = kReqReady;
    rspV = !kRst && !kMemStop && memDue.size() > 0 && memDue[0] <= cycleNo &&
           (!kJitter || $urandom_range(0, 3) != 0);
    bus.imem_rsp_valid   = rspV;
    bus.imem_rsp_data    = rspV ? memData(memAddr[0]) : $urandom();
    #1;
    expReqV = !kRst && !kRedir && qPc.size() < FQ && mOut < MAXO;
    expIfV  = !kRst && qPc.size() > 0 && qFilled[0];
    if (started) begin
      chk("req_valid", bus.imem_req_valid, expReqV);
      chk("req_addr", bus.imem_req_addr, mPc);
      chk("if_valid", bus.if_valid, expIfV);
      if (expIfV) begin
        chk("if_pc", bus.if_pc, qPc[0]);
        chk("if_instr", bus.if_instr, qData[0]);
      end
    end
    if (kRst) dut2Log.delete();
    else if (bus2.imem_req_valid) dut2Log.push_back(bus2.imem_req_addr);

    if (kRst) begin
      mPc = 32'h0; mOut = 0; mDrop = 0;
      qPc.delete(); qData.delete(); qFilled.delete();
      memDue.delete(); memAddr.delete();
      issueLog.delete(); delivLog.delete();
      discards = 0; relCycle = 0; firstDelivRel = -1; started = 1;
    end else begin
      reqFire = expReqV && kReqReady;
      pop     = expIfV && kIfReady && !kRedir;
      a = 32'h0;
      if (rspV) begin
        a = memAddr.pop_front();
        void'(memDue.pop_front());
      end
      if (kRedir) begin
        if (rspV) discards++;
        mOut  -= int'(rspV);
        mDrop  = mOut;
        qPc.delete(); qData.delete(); qFilled.delete();
        mPc = kRedirPc;
      end else begin
        if (rspV) begin
          if (mDrop > 0) begin
            mDrop--;
            discards++;
          end else begin
            idx = -1;
            foreach (qFilled[i]) if (!qFilled[i] && idx < 0) idx = i;
            if (idx >= 0) begin
              qData[idx]   = memData(a);
              qFilled[idx] = 1'b1;
            end
          end
        end
        if (pop) begin
          if (delivLog.size() == 0) firstDelivRel = relCycle;
          delivLog.push_back(qPc[0]);
          void'(qPc.pop_front()); void'(qData.pop_front()); void'(qFilled.pop_front());
        end
        if (reqFire) begin
          qPc.push_back(mPc); qData.push_back(32'h0); qFilled.push_back(1'b0);
          memDue.push_back(cycleNo + kLat); memAddr.push_back(mPc);
          issueLog.push_back(mPc);
          mPc += 32'd4;
        end
        mOut += int'(reqFire) - int'(rspV);
      end
      relCycle++;
    end
    cycleNo++;
  endtask

  task automatic doReset(input int n);
    kRst = 1; kRedir = 0;
    repeat (n) cycle();
    kRst = 0;
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    kRedir = 1; kRedirPc = pc;
    cycle();
    kRedir = 0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; redirValid = 1'b0; redirPc = 32'h0;
    bus.if_ready = 1'b0; bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data = 32'h0; bus2.if_ready = 1'b0;
    kIfReady = 1; kReqReady = 1; kLat = 1; kMemStop = 0; kJitter = 0;
    kRedir = 0; kRedirPc = 32'h0; kRst = 1;

    // streaming with 1-cycle memory
    doReset(3);
    repeat (20) cycle();
    chk("p1_pc0", at(delivLog, 0), 32'h0);
    chk("p1_pc1", at(delivLog, 1), 32'h4);
    chk("p1_pc2", at(delivLog, 2), 32'h8);
    chk("p1_startup", firstDelivRel, 2);
    chk("p1_count", delivLog.size(), 18);

    // decode stall fills the queue
    doReset(2);
    kIfReady = 0;
    repeat (10) cycle();
    chk("p2_issued", issueLog.size(), 4);
    chk("p2_last_addr", at(issueLog, 3), 32'hC);
    chk("p2_req_low", bus.imem_req_valid, 1'b0);
    chk("p2_hold_pc", bus.if_pc, 32'h0);
    kIfReady = 1;
    repeat (6) cycle();
    for (int i = 0; i < 4; i++) chk("p2_resume", at(delivLog, i), 32'(i * 4));

    // redirect with three in flight, one arriving in the redirect cycle
    doReset(2);
    kLat = 3;
    repeat (3) cycle();
    redirectTo(32'h100);
    repeat (12) cycle();
    chk("p3_discards", discards, 3);
    chk("p3_first", at(delivLog, 0), 32'h100);
    chk("p3_second", at(delivLog, 1), 32'h104);

    // back-to-back redirects two cycles apart
    doReset(2);
    repeat (3) cycle();
    redirectTo(32'h100);
    cycle();
    redirectTo(32'h200);
    repeat (14) cycle();
    bad = 0;
    foreach (delivLog[i]) if (delivLog[i] < 32'h200) bad++;
    chk("p4_discards", discards, 4);
    chk("p4_first", at(delivLog, 0), 32'h200);
    chk("p4_stale", bad, 0);
    chk("p4_issue100", at(issueLog, 3), 32'h100);
    chk("p4_issue200", at(issueLog, 4), 32'h200);

    // silent memory plus repeated redirects saturates outstanding
    doReset(2);
    kLat = 1; kMemStop = 1;
    repeat (6) cycle();
    redirectTo(32'h300);
    repeat (6) cycle();
    redirectTo(32'h400);
    repeat (6) cycle();
    chk("p5_issued", issueLog.size(), 8);
    chk("p5_issue300", at(issueLog, 4), 32'h300);
    chk("p5_outstanding", mOut, MAXO);
    chk("p5_req_low", bus.imem_req_valid, 1'b0);
    chk("p5_if_low", bus.if_valid, 1'b0);
    kMemStop = 0;
    doReset(2);
    repeat (6) cycle();
    chk("p5_rst_issue", at(issueLog, 0), 32'h0);
    chk("p5_rst_deliv", at(delivLog, 0), 32'h0);
    chk("p5_rst_startup", firstDelivRel, 2);

    // randomized traffic
    kJitter = 1;
    for (int n = 0; n < 3000; n++) begin
      kIfReady  = $urandom_range(0, 3) != 0;
      kReqReady = $urandom_range(0, 4) != 0;
      kLat      = $urandom_range(1, 4);
      kRedir    = $urandom_range(0, 24) == 0;
      kRedirPc  = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) kMemStop = !kMemStop;
      kRst      = $urandom_range(0, 499) == 0;
      cycle();
    end
    kJitter = 0; kMemStop = 0; kRedir = 0; kRst = 0; kIfReady = 1; kReqReady = 1;

    // address wrap on the RESET_PC=0xFFFFFFF8 instance
    doReset(2);
    repeat (10) cycle();
    chk("wrap_count", dut2Log.size(), 4);
    chk("wrap_a0", at(dut2Log, 0), 32'hFFFF_FFF8);
    chk("wrap_a1", at(dut2Log, 1), 32'hFFFF_FFFC);
    chk("wrap_a2", at(dut2Log, 2), 32'h0000_0000);
    chk("wrap_a3", at(dut2Log, 3), 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-register PC + adder + combinational IRAM fetch path.
- Owns the fetch PC and issues requests to a latency-tolerant instruction memory over a valid/ready request port with an in-order response port.
- Buffers returned instructions with their PCs in a FQ_DEPTH-entry queue and presents them to the IF/ID boundary through a valid/ready handshake.
- Supports redirect (branch/jump) with discard of in-flight responses.

Parameters:
ADDR_WIDTH, 32, PC / instruction address width
INSTR_WIDTH, 32, instruction width; PC step = INSTR_WIDTH/8
FQ_DEPTH, 4, fetch-queue entries (power of two, >=2)
MAX_OUTSTANDING, 2*FQ_DEPTH, cap on issued-but-unanswered requests, including requests to be dropped
RESET_PC, 0, PC loaded by reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
redirect_valid  in  1  load new PC and flush the queue this cycle
redirect_pc  in  ADDR_WIDTH  target PC
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  request address
imem_rsp_valid  in  1  response valid; responses are in order, no backpressure
imem_rsp_data  in  INSTR_WIDTH  returned instruction
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts (low = hazard stall)
if_instr  out  INSTR_WIDTH  instruction at queue head
if_pc  out  ADDR_WIDTH  PC of if_instr

Behaviour:
- Reset (rst high at a clock edge):
  - fetch_pc = RESET_PC.
  - Queue emptied; outstanding = 0; drop_cnt = 0.
  - if_valid = 0 and imem_req_valid = 0 while rst is high.
  - imem_req_addr = RESET_PC.
  - The memory shares rst, so no responses survive reset.
- Queue slot state: a slot is allocated at issue, storing its PC. It becomes filled when its response arrives. Occupancy counts allocated slots, filled or not.
- Issue:
  - imem_req_valid = !rst && !redirect_valid && occupancy < FQ_DEPTH && outstanding < MAX_OUTSTANDING.
  - imem_req_addr = fetch_pc.
  - On req handshake: allocate tail slot with fetch_pc; fetch_pc += INSTR_WIDTH/8, wrapping modulo 2^ADDR_WIDTH; outstanding += 1.
- Response:
  - If drop_cnt > 0, discard the data and decrement drop_cnt.
  - Otherwise fill the oldest allocated-unfilled slot.
  - outstanding -= 1 in both cases.
  - Issue and response in the same cycle leave outstanding unchanged.
- Output:
  - if_valid = head slot allocated and filled; if_instr/if_pc driven from the head.
  - Pop on if_valid && if_ready.
  - Pop, allocate and fill may all occur in one cycle.
  - With a memory that answers the next cycle, a request issued in cycle N appears at if_valid in cycle N+2.
- Redirect (redirect_valid high):
  - Has priority over issue and pop; no pop occurs even if if_ready is high.
  - Next cycle: fetch_pc = redirect_pc, queue empty, if_valid = 0.
  - drop_cnt_next = outstanding - (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - First request to redirect_pc issues the cycle after the redirect.
  - Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Full: occupancy == FQ_DEPTH stops issue; if_ready low indefinitely holds all outputs stable.
- No-response protection: outstanding == MAX_OUTSTANDING stops issue (bounds drop_cnt under repeated redirects).
- Counter widths: outstanding and drop_cnt use $clog2(MAX_OUTSTANDING+1) bits. Queue pointers use $clog2(FQ_DEPTH) bits with wrap-around plus an occupancy counter.
- Assertions:
  - imem_rsp_valid is never high when outstanding == 0.
  - occupancy never exceeds FQ_DEPTH.

Decomposition:
- Shared package riscv_pkg: ADDR_WIDTH, INSTR_WIDTH, RESET_PC defaults; PC_STEP constant; NOP encoding (32'h00000013) for later flush insertion in IF/ID.
- One sub-module fetch_queue: circular buffer with alloc(pc), fill(data), pop, flush, and head/occupancy outputs.
- fetch_unit holds fetch_pc, the outstanding/drop counters and the issue logic.

Test Plan:
- Reset, then memory with 1-cycle latency and if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, …; one instruction per cycle after 2-cycle startup; imem_req_valid held low during rst.
- if_ready=0 for 10 cycles -> exactly FQ_DEPTH=4 requests issued (0x0–0xC); imem_req_valid low after that; if_pc held at 0x0; resume delivers 0x0–0xC in order with no loss.
- Memory latency 3 with 3 requests in flight; redirect_valid to 0x100 -> 3 responses dropped; next if_pc = 0x100; no stale instruction delivered.
- Redirect coinciding with a response, then a second redirect to 0x200 two cycles later -> drop_cnt counts exactly match; only 0x200, 0x204, … delivered.
- RESET_PC = 0xFFFFFFF8, free-running fetch -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap-around).
- Memory stops responding with repeated redirects -> outstanding saturates at MAX_OUTSTANDING=8; no further requests; rst mid-operation returns to the RESET_PC fetch with an empty queue.
